// File: rtl/tile_query_arbiter_if.sv
// Requester-side bundle for shared tilemap wall lookups.
interface tile_query_arbiter_if #(
    parameter int NUM_REQ = 5,
    parameter int COL_W   = 5,
    parameter int ROW_W   = 5
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*COL_W-1:0] req_col;
    logic [NUM_REQ*ROW_W-1:0] req_row;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic                     rsp_wall;

    modport master (
        output req, req_col, req_row,
        input  gnt, rsp_valid, rsp_wall
    );

    modport slave (
        input  req, req_col, req_row,
        output gnt, rsp_valid, rsp_wall
    );
endinterface

// File: rtl/tile_query_arbiter.sv
// Round-robin arbiter sharing the wall RAM between player and ghosts.
module tile_query_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int COL_NUM = 32,
    parameter int ROW_NUM = 24,
    parameter int COL_W   = 5,
    parameter int ROW_W   = 5,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    tile_query_arbiter_if.slave bus,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_rd_data
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [ADDR_W:0] addr_ext_t;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_ptr_nxt;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] win_oh;
    logic               win_any;
    logic [COL_W-1:0]   win_col;
    logic [ROW_W-1:0]   win_row;
    addr_ext_t          win_addr;
    logic               win_oor;
    logic               oor_a;
    logic               oor_d;

    // A requester being granted this cycle is masked so it cannot win twice.
    assign elig = bus.req & ~bus.gnt;

    always_comb begin
        win_oh     = '0;
        win_any    = 1'b0;
        win_col    = '0;
        win_row    = '0;
        rr_ptr_nxt = rr_ptr;
        for (int o = 0; o < NUM_REQ; o++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_any && elig[i] &&
                    ((int'(rr_ptr) + o == i) ||
                     (int'(rr_ptr) + o == i + NUM_REQ))) begin
                    win_any    = 1'b1;
                    win_oh[i]  = 1'b1;
                    win_col    = bus.req_col[i*COL_W +: COL_W];
                    win_row    = bus.req_row[i*ROW_W +: ROW_W];
                    rr_ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
                end
            end
        end
    end

    always_comb begin
        win_addr = addr_ext_t'(win_row) * addr_ext_t'(COL_NUM)
                 + addr_ext_t'(win_col);
        // Anything past the map edge reads as solid wall.
        win_oor  = (int'(win_col) >= COL_NUM) ||
                   (int'(win_row) >= ROW_NUM) ||
                   win_addr[ADDR_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= '0;
            bus.gnt       <= '0;
            ram_rd_en     <= 1'b0;
            ram_addr      <= '0;
            oor_a         <= 1'b0;
            bus.rsp_valid <= '0;
            oor_d         <= 1'b0;
        end else begin
            rr_ptr    <= rr_ptr_nxt;
            bus.gnt   <= win_oh;
            ram_rd_en <= win_any && !win_oor;
            if (win_any && !win_oor) begin
                ram_addr <= win_addr[ADDR_W-1:0];
            end
            oor_a         <= win_any && win_oor;
            bus.rsp_valid <= bus.gnt;
            oor_d         <= oor_a;
        end
    end

    assign bus.rsp_wall = (|bus.rsp_valid) & (oor_d | ram_rd_data);
endmodule

// File: tb/tb_tile_query_arbiter.sv
// Randomized bench for tile_query_arbiter against a behavioural model.
module tb_tile_query_arbiter;
    localparam int NUM_REQ = 5;
    localparam int COL_NUM = 32;
    localparam int ROW_NUM = 24;
    localparam int COL_W   = 5;
    localparam int ROW_W   = 5;
    localparam int ADDR_W  = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_data;

    logic               mem [0:1023];
    logic [NUM_REQ-1:0] t_req;
    logic [COL_W-1:0]   t_col [NUM_REQ];
    logic [ROW_W-1:0]   t_row [NUM_REQ];

    int vectors;
    int miscompares;
    int mode;

    int                 m_ptr;
    int                 m_win;
    logic [ADDR_W-1:0]  m_addr;
    logic [NUM_REQ-1:0] e_gnt;
    logic               e_rden;
    logic [NUM_REQ-1:0] e_rv;
    logic               e_rw;
    logic [NUM_REQ-1:0] p_rv;
    logic               p_rw;
    logic [NUM_REQ-1:0] s_req;
    logic [NUM_REQ-1:0] s_mask;
    logic               s_reset;
    int                 waitc [NUM_REQ];

    always #5 clk = ~clk;

    tile_query_arbiter_if #(
        .NUM_REQ(NUM_REQ), .COL_W(COL_W), .ROW_W(ROW_W)
    ) bus ();

    tile_query_arbiter #(
        .NUM_REQ(NUM_REQ), .COL_NUM(COL_NUM), .ROW_NUM(ROW_NUM),
        .COL_W(COL_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .ram_rd_en  (ram_rd_en),
        .ram_addr   (ram_addr),
        .ram_rd_data(ram_rd_data)
    );

    always_ff @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_addr];
    end

    always_comb begin
        bus.req = t_req;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_col[i*COL_W +: COL_W] = t_col[i];
            bus.req_row[i*ROW_W +: ROW_W] = t_row[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic new_coord(input int i, input bit in_range);
        t_col[i] = COL_W'($urandom_range(0, 31));
        if (in_range) t_row[i] = ROW_W'($urandom_range(0, ROW_NUM - 1));
        else          t_row[i] = ROW_W'($urandom_range(0, 31));
    endtask

    // Predicts what the outputs will show after the coming edge.
    task automatic predict();
        int w;
        int c;
        int r;
        int i;
        logic oor;
        logic [ADDR_W-1:0] a;
        s_reset = reset;
        w = -1;
        if (reset) begin
            m_ptr  = 0;
            e_gnt  = '0;
            e_rden = 1'b0;
            m_addr = '0;
            e_rv   = '0;
            e_rw   = 1'b0;
            p_rv   = '0;
            p_rw   = 1'b0;
            s_req  = '0;
            s_mask = '0;
        end else begin
            e_rv   = p_rv;
            e_rw   = p_rw;
            s_req  = t_req;
            s_mask = '0;
            if (m_win >= 0) s_mask[m_win] = 1'b1;
            for (int o = 0; o < NUM_REQ; o++) begin
                i = (m_ptr + o) % NUM_REQ;
                if (w < 0 && t_req[i] && i != m_win) w = i;
            end
            if (w >= 0) begin
                c      = int'(t_col[w]);
                r      = int'(t_row[w]);
                oor    = (c >= COL_NUM) || (r >= ROW_NUM);
                a      = ADDR_W'(r * COL_NUM + c);
                e_gnt  = NUM_REQ'(1 << w);
                e_rden = !oor;
                if (!oor) m_addr = a;
                p_rv   = e_gnt;
                p_rw   = oor ? 1'b1 : mem[a];
                m_ptr  = (w + 1) % NUM_REQ;
            end else begin
                e_gnt  = '0;
                e_rden = 1'b0;
                p_rv   = '0;
                p_rw   = 1'b0;
            end
        end
        m_win = w;
    endtask

    task automatic policy();
        case (mode)
            0: if (m_win >= 0) t_req[m_win] = 1'b0;
            2: if (m_win >= 0) new_coord(m_win, 1'b1);
            default: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i == m_win) begin
                        if ($urandom_range(0, 1) == 0) t_req[i] = 1'b0;
                        else new_coord(i, 1'b0);
                    end else if (!t_req[i]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            t_req[i] = 1'b1;
                            new_coord(i, 1'b0);
                        end
                    end else if ($urandom_range(0, 19) == 0) begin
                        t_req[i] = 1'b0;
                    end
                end
            end
        endcase
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        #1;
        check("gnt", 32'(bus.gnt), 32'(e_gnt));
        check("ram_rd_en", 32'(ram_rd_en), 32'(e_rden));
        check("ram_addr", 32'(ram_addr), 32'(m_addr));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
        check("rsp_wall", 32'(bus.rsp_wall), 32'(e_rw));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (s_reset || !s_req[i]) begin
                waitc[i] = 0;
            end else begin
                if (!s_mask[i]) waitc[i]++;
                if (bus.gnt[i]) begin
                    check("wait_bound", 32'(waitc[i] <= NUM_REQ), 32'd1);
                    waitc[i] = 0;
                end
            end
        end
        policy();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_ptr       = 0;
        m_win       = -1;
        m_addr      = '0;
        e_gnt       = '0;
        e_rden      = 1'b0;
        e_rv        = '0;
        e_rw        = 1'b0;
        p_rv        = '0;
        p_rw        = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) waitc[i] = 0;
        for (int a = 0; a < 1024; a++) mem[a] = 1'($urandom_range(0, 1));
        mem[103] = 1'b1;
        mem[0]   = 1'b0;
        mem[767] = 1'b1;

        mode  = 0;
        t_req = '1;
        for (int i = 0; i < NUM_REQ; i++) new_coord(i, 1'b1);
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("first_gnt", 32'(bus.gnt), 32'd1);
        repeat (8) step();

        t_col[2] = 5'd7;
        t_row[2] = 5'd3;
        t_req[2] = 1'b1;
        step();
        check("single_gnt", 32'(bus.gnt), 32'b00100);
        check("single_addr", 32'(ram_addr), 32'd103);
        check("single_rden", 32'(ram_rd_en), 32'd1);
        step();
        check("single_rsp", 32'(bus.rsp_valid), 32'b00100);
        check("single_wall", 32'(bus.rsp_wall), 32'd1);
        repeat (2) step();

        mode  = 2;
        t_req = '1;
        for (int i = 0; i < NUM_REQ; i++) new_coord(i, 1'b1);
        repeat (25) step();
        mode = 0;
        repeat (8) step();

        t_col[1] = 5'd31;
        t_row[1] = 5'd24;
        t_req[1] = 1'b1;
        step();
        check("oor_gnt", 32'(bus.gnt), 32'b00010);
        check("oor_rden", 32'(ram_rd_en), 32'd0);
        step();
        check("oor_rsp", 32'(bus.rsp_valid), 32'b00010);
        check("oor_wall", 32'(bus.rsp_wall), 32'd1);
        repeat (2) step();

        t_col[0] = 5'd0;
        t_row[0] = 5'd0;
        t_req[0] = 1'b1;
        step();
        check("corner0_addr", 32'(ram_addr), 32'd0);
        step();
        check("corner0_wall", 32'(bus.rsp_wall), 32'd0);
        t_col[4] = 5'd31;
        t_row[4] = 5'd23;
        t_req[4] = 1'b1;
        step();
        check("corner767_addr", 32'(ram_addr), 32'd767);
        step();
        check("corner767_wall", 32'(bus.rsp_wall), 32'd1);
        repeat (2) step();

        t_col[3] = 5'd5;
        t_row[3] = 5'd5;
        t_req[3] = 1'b1;
        step();
        check("mid_gnt", 32'(bus.gnt), 32'b01000);
        reset = 1'b1;
        step();
        check("mid_rsp", 32'(bus.rsp_valid), 32'd0);
        reset = 1'b0;
        t_req[0] = 1'b1;
        t_req[3] = 1'b1;
        step();
        check("mid_rr", 32'(bus.gnt), 32'b00001);
        repeat (6) step();

        mode = 1;
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        mode  = 0;
        t_req = '0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
